matmul_engine: RTL and testbench

MATMUL_ENGINE -- requirements
Module: matmul_engine

---
 rtl/matmul_engine_if.sv | 32 +++
 rtl/matmul_engine.sv | 175 +++++++++++++++++
 tb/tb_matmul_engine.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_engine_if.sv
// Memory-side bus of the matrix-multiply engine: controller status,
// A/B read ports, C write port and the engine's status flags.
interface matmul_engine_if #(
  parameter int unsigned N      = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  localparam int unsigned ACC_W = 2 * DATA_W + $clog2(N);

  logic [1:0]        status;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic [ADDR_W-1:0] c_addr;
  logic [ACC_W-1:0]  c_data;
  logic              c_we;
  logic              busy;
  logic              process_finish;

  // Engine side: drives addresses, result and flags.
  modport master (
    input  status, a_data, b_data,
    output a_addr, b_addr, c_addr, c_data, c_we, busy, process_finish
  );

  // Memory/controller side.
  modport slave (
    output status, a_data, b_data,
    input  a_addr, b_addr, c_addr, c_data, c_we, busy, process_finish
  );
endinterface

// File: rtl/matmul_engine.sv
// Sequential N x N unsigned matrix multiplier, C = A * B.
// One MAC per READ/ACC pair, one C write per element; pausable via status.
module matmul_engine #(
  parameter int unsigned N      = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clock,
  input  logic            rst,
  matmul_engine_if.master bus
);
  localparam int unsigned ACC_W = 2 * DATA_W + $clog2(N);
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ACC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [IDX_W-1:0]  j_q, j_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;
  logic [ACC_W-1:0]  c_data_q, c_data_d;
  logic              c_we_q, c_we_d;
  logic              busy_q, busy_d;
  logic              finish_q, finish_d;

  logic              run_c;
  logic [ACC_W-1:0]  prod_c;
  logic [IDX_W-1:0]  k_inc_c;

  // Row-major address of element (r, c).
  function automatic logic [ADDR_W-1:0] rc_addr(input logic [IDX_W-1:0] r,
                                                input logic [IDX_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(N) + ADDR_W'(c);
  endfunction

  // Operands are zero-extended first so the product is full ACC_W width.
  assign run_c   = (bus.status == 2'b01);
  assign prod_c  = ACC_W'(bus.a_data) * ACC_W'(bus.b_data);
  assign k_inc_c = k_q + IDX_W'(1);

  // Next-state, index, accumulator and output computation.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_addr_d = c_addr_q;
    c_data_d = c_data_q;
    c_we_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run_c) begin
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          acc_d    = '0;
          a_addr_d = '0;
          b_addr_d = '0;
          state_d  = S_READ;
        end
      end

      // Addresses were loaded on entry; memory answers during ACC.
      S_READ: begin
        if (run_c) begin
          state_d = S_ACC;
        end
      end

      S_ACC: begin
        if (run_c) begin
          acc_d = acc_q + prod_c;
          if (k_q < LAST_IDX) begin
            k_d      = k_inc_c;
            a_addr_d = rc_addr(i_q, k_inc_c);
            b_addr_d = rc_addr(k_inc_c, j_q);
            state_d  = S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (run_c) begin
          c_we_d   = 1'b1;
          c_addr_d = rc_addr(i_q, j_q);
          c_data_d = acc_q;
          acc_d    = '0;
          k_d      = '0;
          if (j_q < LAST_IDX) begin
            j_d = j_q + IDX_W'(1);
          end else begin
            j_d = '0;
            i_d = i_q + IDX_W'(1);
          end
          if ((i_q == LAST_IDX) && (j_q == LAST_IDX)) begin
            state_d = S_DONE;
          end else begin
            a_addr_d = rc_addr(i_d, '0);
            b_addr_d = rc_addr('0, j_d);
            state_d  = S_READ;
          end
        end
      end

      // Terminal until reset; status is ignored.
      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d   = (state_d == S_READ) || (state_d == S_ACC) || (state_d == S_WRITE);
    finish_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      c_data_q <= '0;
      c_we_q   <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
      c_data_q <= c_data_d;
      c_we_q   <= c_we_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  assign bus.a_addr         = a_addr_q;
  assign bus.b_addr         = b_addr_q;
  assign bus.c_addr         = c_addr_q;
  assign bus.c_data         = c_data_q;
  assign bus.c_we           = c_we_q;
  assign bus.busy           = busy_q;
  assign bus.process_finish = finish_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: synchronous A/B memories, scoreboard
// of expected C writes, edge counting relative to the start edge.
module tb_matmul_engine;
  localparam int unsigned N      = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  always #5 clock = ~clock;

  matmul_engine_if #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  matmul_engine #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem_a [16];
  logic [DATA_W-1:0] mem_b [16];

  // Synchronous read memories: data one cycle after address.
  always @(posedge clock) begin
    bus.a_data <= mem_a[bus.a_addr];
    bus.b_data <= mem_b[bus.b_addr];
  end

  int checks   = 0;
  int fails    = 0;
  int edge_cnt = 0;
  int first_we = -1;
  int fin_edge = -1;
  int wr_cnt   = 0;
  int exp_addr [$];
  int exp_data [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then sample on the falling edge and score C writes.
  task automatic tick();
    int ea;
    int ed;
    @(posedge clock);
    edge_cnt++;
    @(negedge clock);
    if (bus.c_we === 1'b1) begin
      wr_cnt++;
      if (first_we < 0) first_we = edge_cnt;
      checks++;
      assert (exp_addr.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_we: observed write addr=%0d data=0x%0h, expected no write",
               bus.c_addr, bus.c_data);
      end
      if (exp_addr.size() != 0) begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        check("c_addr", 32'(bus.c_addr), 32'(ea));
        check("c_data", 32'(bus.c_data), 32'(ed));
      end
    end
    if ((bus.process_finish === 1'b1) && (fin_edge < 0)) fin_edge = edge_cnt;
  endtask

  task automatic push_golden(input int count);
    int sum;
    for (int m = 0; m < count; m++) begin
      sum = 0;
      for (int k = 0; k < 3; k++)
        sum += int'(mem_a[(m / 3) * 3 + k]) * int'(mem_b[k * 3 + (m % 3)]);
      exp_addr.push_back(m);
      exp_data.push_back(sum);
    end
  endtask

  // Edge 0 is the edge that samples status==01.
  task automatic start_run();
    bus.status = 2'b01;
    edge_cnt   = -1;
    first_we   = -1;
    fin_edge   = -1;
    wr_cnt     = 0;
    tick();
  endtask

  task automatic run_to_finish(input int bound);
    int n = 0;
    while ((bus.process_finish !== 1'b1) && (n < bound)) begin
      tick();
      n++;
    end
    check("finish_reached", 32'(bus.process_finish), 32'd1);
  endtask

  task automatic run_to_edge(input int target);
    int n = 0;
    while ((edge_cnt < target) && (n < 200)) begin
      tick();
      n++;
    end
    check("reached_edge", 32'(edge_cnt), 32'(target));
  endtask

  task automatic do_reset(input int cycles);
    rst        = 1'b1;
    bus.status = 2'b00;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_a_addr"}, 32'(bus.a_addr), 32'd0);
    check({tag, "_b_addr"}, 32'(bus.b_addr), 32'd0);
    check({tag, "_c_addr"}, 32'(bus.c_addr), 32'd0);
    check({tag, "_c_data"}, 32'(bus.c_data), 32'd0);
    check({tag, "_c_we"},   32'(bus.c_we),   32'd0);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_finish"}, 32'(bus.process_finish), 32'd0);
  endtask

  initial begin
    bus.status = 2'b00;
    for (int m = 0; m < 16; m++) begin
      mem_a[m] = '0;
      mem_b[m] = '0;
    end

    // Reset held several cycles.
    repeat (3) tick();
    check_zero_outputs("reset");
    rst = 1'b0;

    // Idle: status 11 and 10 do not start the engine.
    bus.status = 2'b11;
    repeat (4) tick();
    check("idle11_busy", 32'(bus.busy), 32'd0);
    check("idle11_a_addr", 32'(bus.a_addr), 32'd0);
    bus.status = 2'b10;
    repeat (4) tick();
    check("idle10_busy", 32'(bus.busy), 32'd0);
    check("idle10_finish", 32'(bus.process_finish), 32'd0);
    check("idle_writes", 32'(wr_cnt), 32'd0);

    // Identity: A = I, B = 1..9, so C = 1..9 in order.
    for (int m = 0; m < 9; m++) begin
      mem_a[m] = ((m % 4) == 0) ? 8'd1 : 8'd0;
      mem_b[m] = 8'(m + 1);
      exp_addr.push_back(m);
      exp_data.push_back(m + 1);
    end
    start_run();
    check("run_busy", 32'(bus.busy), 32'd1);
    run_to_finish(200);
    check("id_first_we_commit_edge", 32'(first_we + 1), 32'd8);
    check("id_finish_edge", 32'(fin_edge), 32'd63);
    check("id_writes", 32'(wr_cnt), 32'd9);
    check("id_queue_empty", 32'(exp_addr.size()), 32'd0);

    // Done hold: status toggles are ignored.
    for (int s = 0; s < 9; s++) begin
      bus.status = (s < 3) ? 2'b01 : ((s < 6) ? 2'b11 : 2'b00);
      tick();
      check("done_finish", 32'(bus.process_finish), 32'd1);
      check("done_busy", 32'(bus.busy), 32'd0);
    end
    do_reset(1);
    check("done_cleared", 32'(bus.process_finish), 32'd0);

    // Max values: no overflow in the 18-bit accumulator.
    for (int m = 0; m < 9; m++) begin
      mem_a[m] = 8'hFF;
      mem_b[m] = 8'hFF;
      exp_addr.push_back(m);
      exp_data.push_back(32'h2FA03);
    end
    start_run();
    run_to_finish(200);
    check("max_writes", 32'(wr_cnt), 32'd9);
    do_reset(2);

    // Pause during the k=1 ACC of element (1,2) (state after edge 38).
    for (int m = 0; m < 9; m++) begin
      mem_a[m] = 8'((m * 37 + 11) & 255);
      mem_b[m] = 8'((m * 53 + 200) & 255);
    end
    push_golden(9);
    start_run();
    run_to_edge(38);
    for (int p = 0; p < 5; p++) begin
      bus.status = 2'b00;
      tick();
      check("pause_a_addr", 32'(bus.a_addr), 32'd4);
      check("pause_b_addr", 32'(bus.b_addr), 32'd5);
      check("pause_c_we", 32'(bus.c_we), 32'd0);
      check("pause_busy", 32'(bus.busy), 32'd1);
    end
    bus.status = 2'b01;
    run_to_finish(200);
    check("pause_finish_edge", 32'(fin_edge), 32'd68);
    check("pause_writes", 32'(wr_cnt), 32'd9);
    check("pause_queue_empty", 32'(exp_addr.size()), 32'd0);
    do_reset(2);

    // Reset mid-run during element (2,0); rst wins over status==01.
    push_golden(6);
    start_run();
    run_to_edge(44);
    rst = 1'b1;
    tick();
    check_zero_outputs("midrst");
    check("midrst_writes", 32'(wr_cnt), 32'd6);
    check("midrst_queue_empty", 32'(exp_addr.size()), 32'd0);
    repeat (2) tick();
    check("midrst_hold_busy", 32'(bus.busy), 32'd0);
    check("midrst_hold_b_addr", 32'(bus.b_addr), 32'd0);
    rst        = 1'b0;
    bus.status = 2'b00;
    tick();
    push_golden(9);
    start_run();
    run_to_finish(200);
    check("restart_finish_edge", 32'(fin_edge), 32'd63);
    check("restart_writes", 32'(wr_cnt), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
